// File: rtl/ge_add.sv
// rtl/ge_add.sv - Ed25519 extended + cached point addition on one shared field multiplier
//
// Computes R = P + Q with P in extended coordinates (X:Y:Z:T) and Q in
// cached form (Y+X, Y-X, 2dT, Z). Results are in completed coordinates.
// Field elements are 10 signed 32-bit limbs, limb 0 in bits [319:288].
//
// Ports:
//    clk                     clock, rising edge
//    rst                     synchronous active-high reset
//    p_x, p_y, p_z, p_t      point P operands (320 bits each)
//    q_yplusx, q_yminusx,
//    q_t2d, q_z              point Q operands (320 bits each)
//    valid                   start request, sampled only in IDLE
//    r_x, r_y, r_z, r_t      registered result
//    done                    registered completion flag
//
// Configuration macro GE_ADD_DONE_HOLD_EN: when defined, done stays high from
// completion until the cycle after the next accepted valid (or rst); when
// undefined, done is a single-cycle pulse.
module ge_add (
   input  logic         clk,
   input  logic         rst,
   input  logic [319:0] p_x,
   input  logic [319:0] p_y,
   input  logic [319:0] p_z,
   input  logic [319:0] p_t,
   input  logic [319:0] q_yplusx,
   input  logic [319:0] q_yminusx,
   input  logic [319:0] q_t2d,
   input  logic [319:0] q_z,
   input  logic         valid,
   output logic [319:0] r_x,
   output logic [319:0] r_y,
   output logic [319:0] r_z,
   output logic [319:0] r_t,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

   // Limb carry sequence of the reference multiply; limb 9 wraps into limb 0 times 19.
   localparam int CARRY_ORDER [12] = '{0, 4, 1, 5, 2, 6, 3, 7, 4, 8, 9, 0};

   function automatic logic [319:0] fe_add(input logic [319:0] a, input logic [319:0] b);
      logic [319:0] r;
      for (int n = 0; n < 10; n++)
         r[319-32*n -: 32] = a[319-32*n -: 32] + b[319-32*n -: 32];
      return r;
   endfunction

   function automatic logic [319:0] fe_sub(input logic [319:0] a, input logic [319:0] b);
      logic [319:0] r;
      for (int n = 0; n < 10; n++)
         r[319-32*n -: 32] = a[319-32*n -: 32] - b[319-32*n -: 32];
      return r;
   endfunction

   function automatic logic [319:0] fe_mul(input logic [319:0] f, input logic [319:0] g);
      logic signed [63:0] h [10];
      logic signed [63:0] fi, gj, term, c;
      logic [319:0] r;
      int k, src;
      for (int n = 0; n < 10; n++) h[n] = '0;
      for (int i = 0; i < 10; i++) begin
         fi = {{32{f[319-32*i]}}, f[319-32*i -: 32]};
         for (int j = 0; j < 10; j++) begin
            gj = {{32{g[319-32*j]}}, g[319-32*j -: 32]};
            term = fi * gj;
            // Odd limbs sit half a bit high, so odd*odd products need doubling.
            if ((i % 2 == 1) && (j % 2 == 1)) term = term <<< 1;
            // Wrap past 2^255 folds back with weight 19.
            if (i + j >= 10) term = term * 64'sd19;
            k = (i + j) % 10;
            h[k] = h[k] + term;
         end
      end
      for (int s = 0; s < 12; s++) begin
         src = CARRY_ORDER[s];
         if (src % 2 == 1) begin
            c = (h[src] + 64'sd16777216) >>> 25;
            h[src] = h[src] - (c <<< 25);
         end else begin
            c = (h[src] + 64'sd33554432) >>> 26;
            h[src] = h[src] - (c <<< 26);
         end
         if (src == 9) h[0] = h[0] + c * 64'sd19;
         else          h[src+1] = h[src+1] + c;
      end
      for (int n = 0; n < 10; n++) r[319-32*n -: 32] = h[n][31:0];
      return r;
   endfunction

   state_t       state_q, state_d;
   logic [1:0]   cnt_q, cnt_d;
   logic [319:0] px_q, py_q, pz_q, pt_q, px_d, py_d, pz_d, pt_d;
   logic [319:0] qp_q, qm_q, qt_q, qz_q, qp_d, qm_d, qt_d, qz_d;
   logic [319:0] a_q, b_q, c_q, zz_q, a_d, b_d, c_d, zz_d;
   logic [319:0] rx_q, ry_q, rz_q, rt_q, rx_d, ry_d, rz_d, rt_d;
   logic         done_q, done_d;
   logic [319:0] mul_a, mul_b, mul_r, d_full;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      px_d = px_q; py_d = py_q; pz_d = pz_q; pt_d = pt_q;
      qp_d = qp_q; qm_d = qm_q; qt_d = qt_q; qz_d = qz_q;
      a_d  = a_q;  b_d  = b_q;  c_d  = c_q;  zz_d = zz_q;
      rx_d = rx_q; ry_d = ry_q; rz_d = rz_q; rt_d = rt_q;
`ifdef GE_ADD_DONE_HOLD_EN
      done_d = done_q;
`else
      done_d = 1'b0;
`endif
      // Shared multiplier operands, one product per MUL cycle.
      case (cnt_q)
         2'd0:    begin mul_a = fe_sub(py_q, px_q); mul_b = qm_q; end
         2'd1:    begin mul_a = fe_add(py_q, px_q); mul_b = qp_q; end
         2'd2:    begin mul_a = pt_q;               mul_b = qt_q; end
         default: begin mul_a = pz_q;               mul_b = qz_q; end
      endcase
      mul_r  = fe_mul(mul_a, mul_b);
      d_full = fe_add(zz_q, zz_q);

      case (state_q)
         IDLE: begin
            if (valid) begin
               px_d = p_x; py_d = p_y; pz_d = p_z; pt_d = p_t;
               qp_d = q_yplusx; qm_d = q_yminusx; qt_d = q_t2d; qz_d = q_z;
               cnt_d   = 2'd0;
               done_d  = 1'b0;
               state_d = MUL;
            end
         end
         MUL: begin
            case (cnt_q)
               2'd0:    a_d  = mul_r;
               2'd1:    b_d  = mul_r;
               2'd2:    c_d  = mul_r;
               default: zz_d = mul_r;
            endcase
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = ADD;
         end
         ADD: begin
            rx_d    = fe_sub(b_q, a_q);
            ry_d    = fe_add(b_q, a_q);
            rz_d    = fe_add(d_full, c_q);
            rt_d    = fe_sub(d_full, c_q);
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         px_q <= '0; py_q <= '0; pz_q <= '0; pt_q <= '0;
         qp_q <= '0; qm_q <= '0; qt_q <= '0; qz_q <= '0;
         a_q  <= '0; b_q  <= '0; c_q  <= '0; zz_q <= '0;
         rx_q <= '0; ry_q <= '0; rz_q <= '0; rt_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         px_q <= px_d; py_q <= py_d; pz_q <= pz_d; pt_q <= pt_d;
         qp_q <= qp_d; qm_q <= qm_d; qt_q <= qt_d; qz_q <= qz_d;
         a_q  <= a_d;  b_q  <= b_d;  c_q  <= c_d;  zz_q <= zz_d;
         rx_q <= rx_d; ry_q <= ry_d; rz_q <= rz_d; rt_q <= rt_d;
         done_q <= done_d;
      end
   end

   assign r_x  = rx_q;
   assign r_y  = ry_q;
   assign r_z  = rz_q;
   assign r_t  = rt_q;
   assign done = done_q;

endmodule

// File: tb/tb_ge_add.sv
// tb/tb_ge_add.sv - scoreboard bench for ge_add
module tb_ge_add;

   typedef struct {
      logic [319:0] px, py, pz, pt, qp, qm, qt, qz;
   } ops_t;

   typedef struct {
      logic [319:0] rx, ry, rz, rt;
      int           start;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [319:0] p_x = '0, p_y = '0, p_z = '0, p_t = '0;
   logic [319:0] q_yplusx = '0, q_yminusx = '0, q_t2d = '0, q_z = '0;
   logic         valid = 1'b0;
   logic [319:0] r_x, r_y, r_z, r_t;
   logic         done;

   ge_add dut (
      .clk(clk), .rst(rst),
      .p_x(p_x), .p_y(p_y), .p_z(p_z), .p_t(p_t),
      .q_yplusx(q_yplusx), .q_yminusx(q_yminusx), .q_t2d(q_t2d), .q_z(q_z),
      .valid(valid),
      .r_x(r_x), .r_y(r_y), .r_z(r_z), .r_t(r_t),
      .done(done)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   n_vec = 0;
   int   n_bad = 0;
   int   done_cnt = 0;
   int   first_lat = -1;
   exp_t sb[$];

   always @(posedge clk) cyc <= cyc + 1;

   localparam logic [319:0] ONE = {32'h00000001, 288'h0};
   localparam logic [319:0] TWO = {32'h00000002, 288'h0};

   ops_t id_ops, vec_ops;
   exp_t id_exp, vec_exp;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every done cycle pops one expected result and checks it.
   always @(negedge clk) begin
      if (done) begin
         exp_t e;
         int   lat;
         done_cnt++;
         if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no completion at cycle %0d", cyc);
         end else begin
            e = sb.pop_front();
            chk("r_x", r_x, e.rx);
            chk("r_y", r_y, e.ry);
            chk("r_z", r_z, e.rz);
            chk("r_t", r_t, e.rt);
            lat = cyc - e.start;
            chk_int("latency_bound", (lat <= 64) ? 1 : 0, 1);
            if (first_lat < 0) first_lat = lat;
            else chk_int("latency_equal", lat, first_lat);
         end
      end
   end

   task automatic drive_ops(input ops_t o);
      p_x = o.px; p_y = o.py; p_z = o.pz; p_t = o.pt;
      q_yplusx = o.qp; q_yminusx = o.qm; q_t2d = o.qt; q_z = o.qz;
   endtask

   // Drives valid for one cycle; pushes the expected result when the DUT should accept it.
   task automatic issue(input ops_t o, input exp_t e, input bit push);
      exp_t x;
      @(posedge clk); #1;
      drive_ops(o);
      valid = 1'b1;
      if (push) begin
         x = e;
         x.start = cyc;
         sb.push_back(x);
      end
      @(posedge clk); #1;
      valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int budget = 200;
      while (sb.size() != 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      if (sb.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s_timeout: got %0d pending expected 0", name, sb.size());
         sb.delete();
      end
      repeat (3) @(posedge clk);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_done"}, {319'h0, done}, 320'h0);
      chk({tag, "_r_x"}, r_x, 320'h0);
      chk({tag, "_r_y"}, r_y, 320'h0);
      chk({tag, "_r_z"}, r_z, 320'h0);
      chk({tag, "_r_t"}, r_t, 320'h0);
   endtask

   initial begin
      int d0;
      int budget;

      id_ops = '{px: 320'h0, py: ONE, pz: ONE, pt: 320'h0,
                 qp: ONE, qm: ONE, qt: 320'h0, qz: ONE};
      id_exp = '{rx: 320'h0, ry: TWO, rz: TWO, rt: TWO, start: 0};

      vec_ops.px = 320'hfee357b0007f52ebfe377ada0050d0460133cb41ff95f756011d7b40ff8cd6dffff6a71a00a2384e;
      vec_ops.py = 320'hfea097ea00e087db00624c9200971965ffa199b1ffb5525dfe3ff23f009dfcf2010c44b800577563;
      vec_ops.pz = 320'hfe6e55e6ff657c15fe3ef28e00dfdbeffe7c6fbbff68221ffe75c13100551e6bffb4de9b005fae49;
      vec_ops.pt = 320'hffdab706ff56ca33fe1fde2400ad90ef01e0d67aff8be8a8fe6ac8ca008772f0fe14ad4100cfa961;
      vec_ops.qp = 320'hffbcaf5f00f20b2efd5a3edaff514f9bfed39b5afee31a21fefb05d7fff31033019e1efbffc3571b;
      vec_ops.qm = 320'h036fe1b5000123640070048e00441801fd8b8db6ffe04875ff03721101558c7fff38924d0042f863;
      vec_ops.qt = 320'hfe07d26d004e2f3600af59a6004b9cb4feb7698900fcfe75feded0e4ff93156500bd54900021897d;
      vec_ops.qz = ONE;
      vec_exp.rx = 320'h025192580092303a027e424c014169a901cc4bb00006b28700515d30fe883853fece1c34fe6f9edd;
      vec_exp.ry = 320'h00937912008a833c002f2b8c00933789fe7596fa00ccfc83017c22d8ffb33141fe4e8786006d7d51;
      vec_exp.rz = 320'hfcb1111afe3e4957fc4ba8e002b6e5c8fd2bf84aff2fbdd3fc53ad8900002b6401220b2e00b8d4f8;
      vec_exp.rt = 320'hfd08467eff57a6fdfcb0215800c889f4fcc5c6a2fe70caa9fd83573b01544e48fdb16f3e00c5e42c;
      vec_exp.start = 0;

      // Reset state
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk_cleared("reset");

      // Identity
      issue(id_ops, id_exp, 1'b1);
      wait_drain("identity");

      // Reference vector
      issue(vec_ops, vec_exp, 1'b1);
      wait_drain("vector");

      // Busy: a second valid mid-run must be ignored
      d0 = done_cnt;
      issue(vec_ops, vec_exp, 1'b1);
      repeat (2) @(posedge clk);
      issue(id_ops, id_exp, 1'b0);
      wait_drain("busy");
      repeat (10) @(posedge clk);
      chk_int("busy_done_count", done_cnt - d0, 1);

      // Reset mid-operation: no done, results cleared
      @(posedge clk); #1;
      drive_ops(vec_ops);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(negedge clk);
      chk_cleared("abort");
      issue(id_ops, id_exp, 1'b1);
      wait_drain("after_reset");

      // Back-to-back: valid held through DONE into the first IDLE cycle
      issue(vec_ops, vec_exp, 1'b1);
      budget = 100;
      @(negedge clk);
      while (!done && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (!done) begin
         n_vec++;
         n_bad++;
         $display("FAIL b2b_first_done: got done=0 expected 1 within budget");
      end else begin
         drive_ops(id_ops);
         valid = 1'b1;
         @(posedge clk); #1;
         begin
            exp_t x;
            x = id_exp;
            x.start = cyc;
            sb.push_back(x);
         end
         @(posedge clk); #1;
         valid = 1'b0;
      end
      wait_drain("b2b");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
